irq_trap_ctrl: RTL

//  Trap-entry side of the machine-mode CSR/MRET path. It samples the external and timer interrupt lines.
//  It publishes MEIP/MTIP pending bits to the CSR file. It gates them with mstatus.MIE and mie.
//  It stalls fetch, waits for an instruction boundary, and then fires a one-cycle trap that does three things:
//  CSR-file write (mepc, mstatus MPIE<=MIE, MIE<=0, MPP<=11), pipeline flush, and redirect to mtvec.
//  It also sequences the MRET redirect to mepc and holds the pipeline for WFI.

---
 rtl/irq_trap_ctrl_if.sv | 66 ++++++
 rtl/irq_trap_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/irq_trap_ctrl_if.sv
// irq_trap_ctrl_if
//   Bundles the trap-entry controller's pipeline/CSR-facing signals.
//   slave  : the controller itself (samples interrupts and pipeline status,
//            drives stall/flush/redirect and the trap-entry CSR update).
//   master : the pipeline and CSR file side.
//
//   Handshake semantics: there is no valid/ready pairing on this bus. Every
//   output is a level that is meaningful on every cycle. trap_we, flush and
//   redirect are single-cycle strobes the consumer acts on at the next clk
//   edge. stall is a level held for as long as fetch/ID must freeze.
//
//   Signals (direction as seen by the controller):
//     ext_irq      in   1   external interrupt, level, asynchronous
//     timer_irq    in   1   timer interrupt, level, clk-synchronous
//     mstatus_mie  in   1   mstatus[3]
//     mie_meie     in   1   mie[11]
//     mie_mtie     in   1   mie[7]
//     mepc_q       in   32  current mepc, MRET target
//     pc_next      in   32  resume address of the oldest uncommitted instr
//     commit_ok    in   1   pipeline is at an instruction boundary
//     is_wfi       in   1   WFI in ID
//     is_mret      in   1   MRET in WB
//     mip_meip     out  1   pending external interrupt (mip[11])
//     mip_mtip     out  1   pending timer interrupt (mip[7])
//     stall        out  1   freeze fetch/ID
//     flush        out  1   kill IF/ID/EX
//     redirect     out  1   load redirect_pc into PC
//     redirect_pc  out  32  redirect target
//     trap_we      out  1   CSR trap-entry update strobe
//     trap_epc     out  32  value for mepc
//     trap_cause   out  32  value for mcause
interface irq_trap_ctrl_if;
    logic        ext_irq;
    logic        timer_irq;
    logic        mstatus_mie;
    logic        mie_meie;
    logic        mie_mtie;
    logic [31:0] mepc_q;
    logic [31:0] pc_next;
    logic        commit_ok;
    logic        is_wfi;
    logic        is_mret;
    logic        mip_meip;
    logic        mip_mtip;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        trap_we;
    logic [31:0] trap_epc;
    logic [31:0] trap_cause;

    modport slave (
        input  ext_irq, timer_irq, mstatus_mie, mie_meie, mie_mtie,
        input  mepc_q, pc_next, commit_ok, is_wfi, is_mret,
        output mip_meip, mip_mtip, stall, flush, redirect, redirect_pc,
        output trap_we, trap_epc, trap_cause
    );

    modport master (
        output ext_irq, timer_irq, mstatus_mie, mie_meie, mie_mtie,
        output mepc_q, pc_next, commit_ok, is_wfi, is_mret,
        input  mip_meip, mip_mtip, stall, flush, redirect, redirect_pc,
        input  trap_we, trap_epc, trap_cause
    );
endinterface

// File: rtl/irq_trap_ctrl.sv
// irq_trap_ctrl
//   Trap-entry side of the machine-mode CSR/MRET path. Synchronises the
//   external interrupt, registers the timer interrupt, publishes both as
//   pending bits, and when an enabled interrupt is taken it stalls fetch,
//   waits for an instruction boundary and fires a one-cycle trap (CSR update,
//   flush, redirect to MTVEC_ADDR). Also sequences the MRET redirect to mepc
//   and holds the pipeline while WFI waits for an interrupt.
//
//   Ports:
//     clk          in   1   clock
//     rst          in   1   synchronous reset, active-low
//     bus          if       irq_trap_ctrl_if.slave (see interface header)
//     dbg_state_o  out  3   current FSM state, for observation only
module irq_trap_ctrl #(
    parameter logic [31:0] MTVEC_ADDR  = 32'h0001_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    irq_trap_ctrl_if.slave       bus,
    output logic [2:0]           dbg_state_o
);

    localparam logic [31:0] CAUSE_EXT = 32'h8000_000B;
    localparam logic [31:0] CAUSE_TMR = 32'h8000_0007;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PEND = 3'd1,
        ST_TAKE = 3'd2,
        ST_RET  = 3'd3,
        ST_WFI  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] ext_sync_q, ext_sync_d;
    logic                   mtip_q, mtip_d;
    logic [31:0]            ret_pc_q, ret_pc_d;
    logic [31:0]            epc_q, epc_d;
    logic [31:0]            cause_q, cause_d;

    logic meip;
    logic ext_pend;
    logic tmr_pend;
    logic pend;
    logic take;

    assign meip     = ext_sync_q[SYNC_STAGES-1];
    assign ext_pend = meip & bus.mie_meie;
    assign tmr_pend = mtip_q & bus.mie_mtie;
    assign pend     = ext_pend | tmr_pend;
    assign take     = bus.mstatus_mie & pend;

    // ext_irq is asynchronous, so it passes through a flop chain; timer_irq
    // is already clk-synchronous and only needs one register.
    always_comb begin
        ext_sync_d    = ext_sync_q;
        ext_sync_d[0] = bus.ext_irq;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            ext_sync_d[i] = ext_sync_q[i-1];
        end
        mtip_d = bus.timer_irq;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            ext_sync_q <= '0;
            mtip_q     <= 1'b0;
            ret_pc_q   <= '0;
            epc_q      <= '0;
            cause_q    <= '0;
        end else begin
            state_q    <= state_d;
            ext_sync_q <= ext_sync_d;
            mtip_q     <= mtip_d;
            ret_pc_q   <= ret_pc_d;
            epc_q      <= epc_d;
            cause_q    <= cause_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        ret_pc_d = ret_pc_q;
        epc_d    = epc_q;
        cause_d  = cause_q;
        case (state_q)
            ST_IDLE: begin
                // MRET wins over a simultaneous take: the interrupt is
                // re-evaluated after MRET has restored MIE.
                if (bus.is_mret) begin
                    state_d  = ST_RET;
                    ret_pc_d = bus.mepc_q;
                end else if (take) begin
                    state_d = ST_PEND;
                end else if (bus.is_wfi) begin
                    state_d = ST_WFI;
                end
            end
            ST_PEND: begin
                if (!take) begin
                    state_d = ST_IDLE;
                end else if (bus.commit_ok) begin
                    state_d = ST_TAKE;
                    epc_d   = bus.pc_next;
                    cause_d = ext_pend ? CAUSE_EXT : CAUSE_TMR;
                end
            end
            // The CSR file clears MIE on the edge leaving TAKE, so returning
            // to IDLE cannot re-enter the trap.
            ST_TAKE: state_d = ST_IDLE;
            ST_RET:  state_d = ST_IDLE;
            ST_WFI: begin
                if (pend) begin
                    state_d = bus.mstatus_mie ? ST_PEND : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the registered state only.
    always_comb begin
        bus.stall       = 1'b0;
        bus.flush       = 1'b0;
        bus.redirect    = 1'b0;
        bus.trap_we     = 1'b0;
        bus.redirect_pc = '0;
        case (state_q)
            ST_PEND: bus.stall = 1'b1;
            ST_WFI:  bus.stall = 1'b1;
            ST_TAKE: begin
                bus.trap_we     = 1'b1;
                bus.flush       = 1'b1;
                bus.redirect    = 1'b1;
                bus.redirect_pc = MTVEC_ADDR;
            end
            ST_RET: begin
                bus.flush       = 1'b1;
                bus.redirect    = 1'b1;
                bus.redirect_pc = ret_pc_q;
            end
            default: ;
        endcase
    end

    assign bus.mip_meip   = meip;
    assign bus.mip_mtip   = mtip_q;
    assign bus.trap_epc   = epc_q;
    assign bus.trap_cause = cause_q;
    assign dbg_state_o    = state_q;

endmodule
